ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends one command byte per request to the keyboard
//  (e.g. 0xED LED set, 0xFF reset) over the shared open-collector ps2_clk/ps2_data lines.
//  Sits beside the PS/2 receive path and shares its pins; rx_inhibit holds the receiver off.
//  Reports completion and the device ACK bit.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before the request (100us @50MHz)
//  TIMEOUT_CYCLES  1000000  max clk cycles between device clock edges before abort (20ms)
// PORTS
//  clk          in   1  system clock; the block's only clock
//  clrn         in   1  asynchronous, active-low reset
//  ps2_clk      in   1  raw PS/2 clock line (asynchronous)
//  ps2_data     in   1  raw PS/2 data line (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low; 0 = release
//  ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release
//  tx_data      in   8  command byte; sampled on accept
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready
//  tx_ready     out  1  1 only in IDLE
//  rx_inhibit   out  1  1 whenever state != IDLE
//  done         out  1  one-cycle pulse at the end of a frame
//  ack_ok       out  1  valid with done: 1 = device drove ACK low
//  timeout_err  out  1  one-cycle pulse on abort
// BEHAVIOUR
//  - Reset (async, clrn=0): state IDLE, both *_oe=0 immediately, tx_ready=1, all other outputs 0,
//    counters 0. Reset mid-frame releases both lines at once; no done pulse.
//  - Sync: ps2_clk and ps2_data pass through a 3-flop synchronizer each.
//    fall = s[2] & ~s[1] (one-cycle pulse per device falling edge). Data is sampled from s[1].
//  - Accept: on tx_valid & tx_ready, latch shreg = {1'b1 stop, ~^tx_data odd parity, tx_data}.
//    tx_valid while busy is ignored.
//  - States:
//    IDLE: oe=00. Accept -> INHIBIT.
//    INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles -> SETUP.
//    SETUP: 1 cycle, clk_oe=1, data_oe=1 (start bit) -> REQ.
//    REQ: clk_oe=0, data_oe=1. Wait for fall #1, then present bit0 -> SHIFT.
//    SHIFT: each fall presents the next bit as data_oe = ~bit, LSB first.
//      Falls #1-8 carry bits 0-7, fall #9 the parity bit, fall #10 the stop bit
//      (data_oe=0, line released). -> ACK after fall #10.
//    ACK: on fall #11, ack_ok_r = ~data_sync -> WAIT_IDLE.
//    WAIT_IDLE: both synced lines high -> IDLE with done=1 and ack_ok=ack_ok_r
//      in the same cycle. tx_ready=1 from the next cycle.
//  - Bit counter is 4 bits and counts falls 1..11; the next fall after 11 is not acted on
//    (state has already left ACK).
//  - Timeout: in REQ, SHIFT, ACK and WAIT_IDLE a counter clears on every fall and on state entry.
//    If it reaches TIMEOUT_CYCLES: release both lines, pulse timeout_err, no done, -> IDLE.
//  - Falls seen in IDLE, INHIBIT or SETUP are ignored (clock is held low by the host anyway).
//  - Counters: ceil(log2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)) bits. No wrap, they saturate
//    at the compare point.
//  - Lines are never driven high; all outputs are registered.
// TESTING (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clocks at 40-clk period)
//  1 tx_data=0xED accepted -> clk_oe high 8 cycles, then 1 cycle both oe high, then clk released.
//    Data bits seen 1,0,1,1,0,1,1,1, parity 1, stop released. Model ACKs -> done=1, ack_ok=1.
//  2 tx_data=0x01 -> parity bit 0. tx_data=0xFF -> parity 1. tx_data=0x00 -> parity 1.
//    Each checked by the model at fall #9.
//  3 Model leaves data high at fall #11 -> done=1, ack_ok=0, both oe=0, tx_ready=1 next cycle.
//  4 Model never clocks after request -> timeout_err pulse exactly 200 cycles after REQ entry,
//    both oe=0, no done.
//  5 clrn pulsed low during SHIFT (after fall #4) -> both oe=0 same cycle, tx_ready=1,
//    next request completes normally.
//  6 tx_valid held high through a frame with new data -> only the first byte is sent.
//    The second byte is accepted in the IDLE cycle after done. rx_inhibit=1 throughout each frame.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives open-collector enables and reports done/ACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SETUP,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_max;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shreg;
    logic [2:0]    r_clk_s;
    logic [2:0]    r_dat_s;
    logic          r_ack;
    logic          r_clk_oe;
    logic          r_data_oe;
    logic          r_ready;
    logic          r_inhibit;
    logic          r_done;
    logic          r_ack_ok;
    logic          r_tout;

    logic w_fall;
    logic w_din;
    logic w_lines_hi;
    logic w_accept;
    logic w_tmo_st;
    logic w_shift;
    logic w_expire;
    logic w_clk_oe;
    logic w_data_oe;
    logic w_ready;
    logic w_inhibit;
    logic w_done;
    logic w_ack_ok;

    assign w_fall     = r_clk_s[2] & ~r_clk_s[1];
    assign w_din      = r_dat_s[1];
    assign w_lines_hi = r_clk_s[1] & r_dat_s[1];
    assign w_accept   = tx_valid & r_ready & (r_state == S_IDLE);
    assign w_tmo_st   = r_state inside {S_REQ, S_SHIFT, S_ACK, S_WAIT};
    assign w_shift    = w_fall & ((r_state == S_REQ) | (r_state == S_SHIFT));
    assign w_cnt_max  = (r_state == S_INHIBIT) ? INH_LAST : TO_LAST;
    // A clean finish in WAIT beats a coincident expiry.
    assign w_expire   = w_tmo_st & (r_cnt == TO_LAST) & ~w_fall &
                        ~((r_state == S_WAIT) & w_lines_hi);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_s <= 3'b111;
            r_dat_s <= 3'b111;
        end else begin
            r_clk_s <= {r_clk_s[1:0], ps2_clk};
            r_dat_s <= {r_dat_s[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_next = S_INHIBIT;
            S_INHIBIT: if (r_cnt == INH_LAST) w_next = S_SETUP;
            S_SETUP:   w_next = S_REQ;
            S_REQ:     if (w_fall) w_next = S_SHIFT;
            S_SHIFT:   if (w_fall && r_bitcnt == 4'd9) w_next = S_ACK;
            S_ACK:     if (w_fall) w_next = S_WAIT;
            S_WAIT:    if (w_lines_hi) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_expire) w_next = S_IDLE;
    end

    always_comb begin
        w_clk_oe  = (w_next == S_INHIBIT) || (w_next == S_SETUP);
        w_data_oe = r_data_oe;
        unique case (1'b1)
            (w_next == S_IDLE),
            (w_next == S_INHIBIT): w_data_oe = 1'b0;
            (w_next == S_SETUP):   w_data_oe = 1'b1;
            w_shift:               w_data_oe = ~r_shreg[0];
            default:               w_data_oe = r_data_oe;
        endcase
        w_done    = (r_state == S_WAIT) && w_lines_hi;
        w_ack_ok  = w_done && r_ack;
        w_ready   = (r_state == S_IDLE) && (w_next == S_IDLE);
        w_inhibit = (w_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt    <= '0;
            r_bitcnt <= 4'd0;
            r_shreg  <= 10'd0;
            r_ack    <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_next != r_state ||
                (w_fall && w_tmo_st)) begin
                r_cnt <= '0;
            end else if (r_cnt != w_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_bitcnt <= 4'd0;
                r_shreg  <= {1'b1, ~^tx_data, tx_data};
                r_ack    <= 1'b0;
            end else begin
                if (w_fall && w_tmo_st && r_state != S_WAIT) begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
                if (w_shift) r_shreg <= {1'b0, r_shreg[9:1]};
                if (w_fall && r_state == S_ACK) r_ack <= ~w_din;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_inhibit <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_tout    <= 1'b0;
        end else begin
            r_clk_oe  <= w_clk_oe;
            r_data_oe <= w_data_oe;
            r_ready   <= w_ready;
            r_inhibit <= w_inhibit;
            r_done    <= w_done;
            r_ack_ok  <= w_ack_ok;
            r_tout    <= w_expire;
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_ready    = r_ready;
    assign rx_inhibit  = r_inhibit;
    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign timeout_err = r_tout;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model on wired-AND lines,
// checks framing, parity, ACK, timeout and reset behaviour.
module tb_ps2_host_tx;
    localparam int INH  = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rx_inhibit;
    logic       done;
    logic       ack_ok;
    logic       timeout_err;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    bit inh_all;

    always #5 clk = ~clk;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_dat_low);

    always @(negedge clk) if (done === 1'b1) n_done++;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_inhibit (rx_inhibit),
        .done       (done),
        .ack_ok     (ack_ok),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    function automatic logic ref_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for request-to-send, clock out nfalls edges,
    // sample the data line while the clock is high.
    task automatic device(input bit do_ack, input int nfalls,
                          output logic [9:0] bits, output bit ok);
        int t;
        t = 0;
        bits = '0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 100);
        if (!ok) return;
        repeat (15) @(negedge clk);
        for (int f = 0; f < nfalls && f < 10; f++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            bits[f] = ps2_data;
            inh_all &= rx_inhibit;
            repeat (HALF - 5) @(negedge clk);
        end
        if (nfalls > 10) begin
            dev_dat_low = do_ack;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            inh_all &= rx_inhibit;
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic finish_frame(input string tag, input bit exp_ack);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ack"}, ack_ok, exp_ack);
        chk({tag, "_oe"}, {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        chk({tag, "_rdy"}, tx_ready, 1);
        chk({tag, "_pulse"}, done, 0);
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input bit do_ack, input bit chk_seq);
        logic [9:0] bits;
        bit ok;
        logic [1:0] exp;
        inh_all = 1'b1;
        send(b);
        if (chk_seq) begin
            for (int i = 0; i < INH + 2; i++) begin
                exp = (i < INH) ? 2'b10 : (i == INH) ? 2'b11 : 2'b01;
                chk($sformatf("%s_seq%0d", tag, i),
                    {ps2_clk_oe, ps2_data_oe}, exp);
                chk($sformatf("%s_inh%0d", tag, i), rx_inhibit, 1);
                if (i < INH + 1) @(negedge clk);
            end
        end
        device(do_ack, 11, bits, ok);
        chk({tag, "_req"}, ok, 1);
        chk({tag, "_byte"}, bits[7:0], b);
        chk({tag, "_par"}, bits[8], ref_parity(b));
        chk({tag, "_stop"}, bits[9], 1);
        chk({tag, "_rxinh"}, inh_all, 1);
        finish_frame(tag, do_ack);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        bit ok;
        int t;
        int k;
        int nd;

        repeat (3) @(negedge clk);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_rdy", tx_ready, 1);
        chk("rst_outs", {rx_inhibit, done, ack_ok, timeout_err}, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        frame("t1", 8'hED, 1'b1, 1'b1);
        frame("t2a", 8'h01, 1'b1, 1'b0);
        frame("t2b", 8'hFF, 1'b1, 1'b0);
        frame("t2c", 8'h00, 1'b1, 1'b0);
        frame("t3", 8'h5A, 1'b0, 1'b0);

        nd = n_done;
        send(8'h55);
        t = 0;
        while (ps2_clk_oe === 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        k = 0;
        while (timeout_err !== 1'b1 && k < TMO + 50) begin
            @(negedge clk);
            k++;
        end
        chk("t4_lat", k, TMO);
        chk("t4_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        chk("t4_pulse", timeout_err, 0);
        chk("t4_nodone", n_done, nd);
        repeat (3) @(negedge clk);

        nd = n_done;
        send(8'hA5);
        device(1'b1, 4, bits, ok);
        chk("t5_req", ok, 1);
        chk("t5_bits", bits[3:0], 4'h5);
        chk("t5_busy", rx_inhibit, 1);
        #2 clrn = 1'b0;
        #1;
        chk("t5_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("t5_rdy", tx_ready, 1);
        chk("t5_rxinh", rx_inhibit, 0);
        @(negedge clk);
        clrn = 1'b1;
        chk("t5_nodone", n_done, nd);
        repeat (2) @(negedge clk);
        frame("t5b", 8'h3C, 1'b1, 1'b0);

        inh_all = 1'b1;
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h96;
        device(1'b1, 11, bits, ok);
        chk("t6a_byte", bits[7:0], 8'hC3);
        chk("t6a_par", bits[8], ref_parity(8'hC3));
        finish_frame("t6a", 1'b1);
        @(negedge clk);
        chk("t6_acc_inh", rx_inhibit, 1);
        chk("t6_acc_clk", ps2_clk_oe, 1);
        tx_valid = 1'b0;
        device(1'b1, 11, bits, ok);
        chk("t6b_byte", bits[7:0], 8'h96);
        chk("t6b_par", bits[8], ref_parity(8'h96));
        chk("t6_rxinh", inh_all, 1);
        finish_frame("t6b", 1'b1);

        for (int i = 0; i < 8; i++) begin
            frame($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
